// File: rtl/router_pkg.sv
// Shared types, widths and byte helpers for the router packet transmitter.
package router_pkg;

   localparam int ADDR_W = 2;
   localparam int LEN_W  = 6;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      HEADER  = 3'd2,
      PAYLOAD = 3'd3,
      PARITY  = 3'd4
   } tx_state_t;

   function automatic logic [DATA_W-1:0] header_byte(input logic [LEN_W-1:0]  len,
                                                     input logic [ADDR_W-1:0] addr);
      return {len, addr};
   endfunction

   function automatic logic [DATA_W-1:0] parity_acc(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module router_tx_buf
   import router_pkg::*;
#(
   parameter int DEPTH = 63
)
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   // Write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Out-of-range addresses read as zero so look-ahead reads stay harmless.
   assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity
// to the router, honouring its busy stall.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int BUF_DEPTH = 63
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic [LEN_W-1:0]  pay_len,
   output logic              tx_idle,
   input  logic              pld_valid,
   input  logic [DATA_W-1:0] pld_data,
   output logic              pld_ready,
   input  logic              busy,
   output logic [DATA_W-1:0] pkt_data,
   output logic              pkt_valid,
   output logic              done,
   output logic              req_err
);

   tx_state_t         state_r, state_s;
   logic [ADDR_W-1:0] dest_r, dest_s;
   logic [LEN_W-1:0]  len_r, len_s;
   logic [LEN_W-1:0]  wr_ptr_r, wr_ptr_s;
   logic [LEN_W-1:0]  rd_ptr_r, rd_ptr_s;
   logic [DATA_W-1:0] par_r, par_s;
   logic [DATA_W-1:0] pkt_data_r, pkt_data_s;
   logic              pkt_valid_r, pkt_valid_s;
   logic              pld_ready_r, pld_ready_s;
   logic              done_r, done_s;
   logic              req_err_r, req_err_s;
   logic              tx_idle_r, tx_idle_s;

   logic              buf_wr_en_s;
   logic [LEN_W-1:0]  buf_rd_addr_s;
   logic [DATA_W-1:0] buf_rd_data_s;

   router_tx_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en_s),
      .wr_addr (wr_ptr_r),
      .wr_data (pld_data),
      .rd_addr (buf_rd_addr_s),
      .rd_data (buf_rd_data_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dest_r      <= 2'd0;
         len_r       <= 6'd0;
         wr_ptr_r    <= 6'd0;
         rd_ptr_r    <= 6'd0;
         par_r       <= 8'h00;
         pkt_data_r  <= 8'h00;
         pkt_valid_r <= 1'b0;
         pld_ready_r <= 1'b0;
         done_r      <= 1'b0;
         req_err_r   <= 1'b0;
         tx_idle_r   <= 1'b1;
      end else begin
         dest_r      <= dest_s;
         len_r       <= len_s;
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         par_r       <= par_s;
         pkt_data_r  <= pkt_data_s;
         pkt_valid_r <= pkt_valid_s;
         pld_ready_r <= pld_ready_s;
         done_r      <= done_s;
         req_err_r   <= req_err_s;
         tx_idle_r   <= tx_idle_s;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead.
   always_comb begin
      state_s       = state_r;
      dest_s        = dest_r;
      len_s         = len_r;
      wr_ptr_s      = wr_ptr_r;
      rd_ptr_s      = rd_ptr_r;
      par_s         = par_r;
      pkt_data_s    = pkt_data_r;
      pkt_valid_s   = pkt_valid_r;
      pld_ready_s   = pld_ready_r;
      done_s        = 1'b0;
      req_err_s     = 1'b0;
      tx_idle_s     = tx_idle_r;
      buf_wr_en_s   = 1'b0;
      buf_rd_addr_s = 6'd0;

      case (state_r)
         IDLE: begin
            tx_idle_s   = 1'b1;
            pkt_valid_s = 1'b0;
            pld_ready_s = 1'b0;
            pkt_data_s  = 8'h00;
            if (start) begin
               if ((dest_addr == ADDR_ILLEGAL) || (pay_len == 6'd0)) begin
                  req_err_s = 1'b1;
               end else begin
                  dest_s      = dest_addr;
                  len_s       = pay_len;
                  par_s       = 8'h00;
                  wr_ptr_s    = 6'd0;
                  rd_ptr_s    = 6'd0;
                  tx_idle_s   = 1'b0;
                  pld_ready_s = 1'b1;
                  state_s     = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end

         LOAD: begin
            if (pld_valid && pld_ready_r) begin
               buf_wr_en_s = 1'b1;
               if (wr_ptr_r == (len_r - 6'd1)) begin
                  // Last byte: fold in the byte and the header, present the header next cycle.
                  wr_ptr_s    = 6'd0;
                  pld_ready_s = 1'b0;
                  pkt_data_s  = header_byte(len_r, dest_r);
                  pkt_valid_s = 1'b1;
                  par_s       = parity_acc(parity_acc(par_r, pld_data),
                                           header_byte(len_r, dest_r));
                  state_s     = HEADER;
               end else begin
                  wr_ptr_s = wr_ptr_r + 6'd1;
                  par_s    = parity_acc(par_r, pld_data);
               end
            end else begin
               state_s = LOAD;
            end
         end

         HEADER: begin
            buf_rd_addr_s = 6'd0;
            if (!busy) begin
               rd_ptr_s   = 6'd0;
               pkt_data_s = buf_rd_data_s;
               state_s    = PAYLOAD;
            end else begin
               state_s = HEADER;
            end
         end

         PAYLOAD: begin
            buf_rd_addr_s = rd_ptr_r + 6'd1;
            if (!busy) begin
               if (rd_ptr_r == (len_r - 6'd1)) begin
                  pkt_data_s  = par_r;
                  pkt_valid_s = 1'b0;
                  state_s     = PARITY;
               end else begin
                  rd_ptr_s   = rd_ptr_r + 6'd1;
                  pkt_data_s = buf_rd_data_s;
               end
            end else begin
               state_s = PAYLOAD;
            end
         end

         PARITY: begin
            if (!busy) begin
               done_s     = 1'b1;
               tx_idle_s  = 1'b1;
               pkt_data_s = 8'h00;
               rd_ptr_s   = 6'd0;
               par_s      = 8'h00;
               state_s    = IDLE;
            end else begin
               state_s = PARITY;
            end
         end

         default: begin
            state_s     = IDLE;
            tx_idle_s   = 1'b1;
            pkt_valid_s = 1'b0;
            pld_ready_s = 1'b0;
            pkt_data_s  = 8'h00;
         end
      endcase
   end

   assign tx_idle   = tx_idle_r;
   assign pld_ready = pld_ready_r;
   assign pkt_data  = pkt_data_r;
   assign pkt_valid = pkt_valid_r;
   assign done      = done_r;
   assign req_err   = req_err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus random packets
// compared against a stream-level reference model.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] dest_addr;
   logic [5:0] pay_len;
   logic       tx_idle;
   logic       pld_valid;
   logic [7:0] pld_data;
   logic       pld_ready;
   logic       busy;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       done;
   logic       req_err;

   int errors = 0;
   int checks = 0;

   logic [7:0] pay [0:63];

   router_pkt_tx #(.BUF_DEPTH(63)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dest_addr (dest_addr),
      .pay_len   (pay_len),
      .tx_idle   (tx_idle),
      .pld_valid (pld_valid),
      .pld_data  (pld_data),
      .pld_ready (pld_ready),
      .busy      (busy),
      .pkt_data  (pkt_data),
      .pkt_valid (pkt_valid),
      .done      (done),
      .req_err   (req_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
      check({tag, "_pkt_data"},  32'(pkt_data),  32'd0);
      check({tag, "_pld_ready"}, 32'(pld_ready), 32'd0);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_req_err"},   32'(req_err),   32'd0);
      check({tag, "_tx_idle"},   32'(tx_idle),   32'd1);
   endtask

   // One packet: start, feed payload with random gaps, then follow the output stream.
   task automatic send_packet(input logic [1:0] d, input int n, input int stall_at,
                              input int stall_cycles, input bit start_mid,
                              input bit rand_busy, input int abort_at);
      logic [7:0] exp_b [0:65];
      logic       exp_v [0:65];
      logic [7:0] par;
      int         k, idx, cyc, stall_left;
      bit         rdy, v, b, mid_done;

      par = {6'(n), d};
      exp_b[0] = {6'(n), d};
      exp_v[0] = 1'b1;
      for (int i = 0; i < n; i++) begin
         par          = par ^ pay[i];
         exp_b[i + 1] = pay[i];
         exp_v[i + 1] = 1'b1;
      end
      exp_b[n + 1] = par;
      exp_v[n + 1] = 1'b0;

      check("idle_before_start", 32'(tx_idle), 32'd1);
      start     = 1'b1;
      dest_addr = d;
      pay_len   = 6'(n);
      step();
      start     = 1'b0;
      dest_addr = 2'($urandom);
      pay_len   = 6'($urandom);
      check("load_ready", 32'(pld_ready), 32'd1);
      check("load_not_idle", 32'(tx_idle), 32'd0);

      k   = 0;
      cyc = 0;
      while (k < n && cyc < 500) begin
         rdy       = pld_ready;
         v         = ($urandom_range(0, 3) != 0);
         pld_valid = v;
         pld_data  = v ? pay[k] : 8'($urandom);
         step();
         cyc++;
         if (v && rdy) k++;
      end
      check("load_count", 32'(k), 32'(n));
      pld_valid = 1'b1;
      pld_data  = 8'hEE;

      idx        = 0;
      cyc        = 0;
      stall_left = stall_cycles;
      mid_done   = 1'b0;
      while (idx < n + 2 && cyc < 1000) begin
         if (abort_at >= 0 && idx == abort_at) begin
            #1 reset = 1'b1;
            #1;
            check_quiet("rst_async");
            step();
            reset     = 1'b0;
            busy      = 1'b0;
            pld_valid = 1'b0;
            for (int c = 0; c < 6; c++) begin
               step();
               check_quiet("post_rst");
            end
            return;
         end
         if (idx == stall_at && stall_left > 0) begin
            b = 1'b1;
            stall_left--;
         end else if (rand_busy) begin
            b = ($urandom_range(0, 3) == 0);
         end else begin
            b = 1'b0;
         end
         busy = b;
         if (start_mid && !mid_done && idx == 3) begin
            start     = 1'b1;
            dest_addr = 2'd0;
            pay_len   = 6'd5;
            mid_done  = 1'b1;
         end else begin
            start = 1'b0;
         end
         check("tx_data",      32'(pkt_data),  32'(exp_b[idx]));
         check("tx_valid",     32'(pkt_valid), 32'(exp_v[idx]));
         check("tx_no_done",   32'(done),      32'd0);
         check("tx_no_reqerr", 32'(req_err),   32'd0);
         check("tx_ready_low", 32'(pld_ready), 32'd0);
         check("tx_not_idle",  32'(tx_idle),   32'd0);
         step();
         cyc++;
         if (!b) idx++;
      end
      start     = 1'b0;
      busy      = 1'b0;
      pld_valid = 1'b0;
      check("tx_count",     32'(idx),       32'(n + 2));
      check("done_pulse",   32'(done),      32'd1);
      check("done_idle",    32'(tx_idle),   32'd1);
      check("done_novalid", 32'(pkt_valid), 32'd0);
      step();
      check("done_single",  32'(done),      32'd0);
      check("after_reqerr", 32'(req_err),   32'd0);
   endtask

   task automatic illegal_start(input logic [1:0] d, input logic [5:0] n, input string tag);
      start     = 1'b1;
      dest_addr = d;
      pay_len   = n;
      step();
      start = 1'b0;
      check({tag, "_req_err"},   32'(req_err),   32'd1);
      check({tag, "_tx_idle"},   32'(tx_idle),   32'd1);
      check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
      check({tag, "_pld_ready"}, 32'(pld_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         check({tag, "_req_err_once"}, 32'(req_err),   32'd0);
         check({tag, "_stay_idle"},    32'(tx_idle),   32'd1);
         check({tag, "_no_valid"},     32'(pkt_valid), 32'd0);
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      dest_addr = 2'd0;
      pay_len   = 6'd0;
      pld_valid = 1'b0;
      pld_data  = 8'h00;
      busy      = 1'b0;
      #3;
      check_quiet("reset");
      step();
      step();
      reset = 1'b0;
      step();
      check_quiet("idle");

      // Nominal single-byte packet: 06, A5, A3.
      pay[0] = 8'hA5;
      send_packet(2'd2, 1, -1, 0, 1'b0, 1'b0, -1);

      // Busy stall of 3 cycles in the middle of a 14-byte payload.
      for (int i = 0; i < 14; i++) pay[i] = 8'($urandom);
      send_packet(2'd1, 14, 7, 3, 1'b0, 1'b0, -1);

      illegal_start(2'd3, 6'd4, "illegal_addr");
      illegal_start(2'd1, 6'd0, "illegal_len");

      // Maximum length with payload 00..3E.
      for (int i = 0; i < 63; i++) pay[i] = 8'(i);
      send_packet(2'd0, 63, -1, 0, 1'b0, 1'b0, -1);

      // Reset after 5 of 10 payload bytes, then a short packet.
      for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
      send_packet(2'd1, 10, -1, 0, 1'b0, 1'b0, 6);
      pay[0] = 8'h3C;
      pay[1] = 8'hC3;
      send_packet(2'd2, 2, -1, 0, 1'b0, 1'b0, -1);

      // Legal start while in PAYLOAD must be ignored.
      for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
      send_packet(2'd2, 8, -1, 0, 1'b1, 1'b0, -1);
      check("after_mid_start_idle", 32'(tx_idle), 32'd1);

      // Random packets with random busy.
      for (int p = 0; p < 6; p++) begin
         int rn;
         rn = $urandom_range(1, 24);
         for (int i = 0; i < rn; i++) pay[i] = 8'($urandom);
         send_packet(2'($urandom_range(0, 2)), rn, -1, 0, 1'b0, 1'b1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
